// File: rtl/fir_window_serializer.sv
// fir_window_serializer: streams a parallel N-sample window out one sample per cycle, oldest first.
module fir_window_serializer #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic           system1000,
  input  logic           system1000_rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           out_last
);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t         state_q, state_d;
  logic [N*W-1:0] win_q, win_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           fire_s, fire_w;
  always_comb begin
    out_valid = state_q == SEND;
    out_last  = out_valid && idx_q == '0;
    out_data  = out_valid ? win_q[idx_q*W +: W] : '0;
    // out_ready feeds in_ready directly so a new window lands on the last-sample cycle
    in_ready  = !system1000_rst && (state_q == IDLE || (out_last && out_ready));
    fire_s    = out_valid && out_ready;
    fire_w    = in_valid && in_ready;
    state_d   = state_q;
    idx_d     = idx_q;
    win_d     = win_q;
    if (fire_w) begin
      win_d   = in_data;
      idx_d   = IDX_TOP;
      state_d = SEND;
    end else if (fire_s) begin
      idx_d   = idx_q == '0 ? IDX_TOP : idx_q - 1'b1;
      state_d = idx_q == '0 ? IDLE : SEND;
    end
  end
  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      idx_q   <= IDX_TOP;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      idx_q   <= idx_d;
    end
  end
endmodule

// File: tb/tb_fir_window_serializer.sv
// tb_fir_window_serializer: directed checks of the window serializer with a reference window builder.
module tb_fir_window_serializer;
  localparam int N = 4;
  localparam int W = 16;
  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [N*W-1:0] builder = '0;
  int             errors = 0;
  int             checks = 0;

  fir_window_serializer #(.N(N), .W(W)) dut (
    .system1000(clk),
    .system1000_rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (out_valid && out_ready) builder <= {builder[(N-1)*W-1:0], out_data};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N*W-1:0] w1, w2, w3, w4;
    logic [W-1:0]   exp2[8];
    logic [W-1:0]   exp3[4];
    logic [W-1:0]   exp4[4];
    logic [3:0]     pat;
    int             k;
    w1 = {16'd10, 16'd20, 16'd30, 16'hFFFF};
    w2 = {16'd400, 16'd300, 16'd200, 16'd100};
    w3 = {16'h0AAA, 16'h0BBB, 16'h0CCC, 16'h0DDD};
    w4 = {16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
    exp2 = '{16'd10, 16'd20, 16'd30, 16'hFFFF, 16'd400, 16'd300, 16'd200, 16'd100};
    exp3 = '{16'h0AAA, 16'h0BBB, 16'h0CCC, 16'h0DDD};
    exp4 = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
    pat = 4'b1001;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    // single window 1,2,3,4
    in_data = {16'd1, 16'd2, 16'd3, 16'd4}; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_data = '1;
    for (int i = 0; i < 4; i++) begin
      chk("t1_valid", out_valid, 1);
      chk("t1_data", out_data, 64'(i + 1));
      chk("t1_last", out_last, i == 3);
      chk("t1_in_ready", in_ready, i == 3);
      tick();
    end
    chk("t1_idle_valid", out_valid, 0);
    chk("t1_idle_in_ready", in_ready, 1);
    chk("t1_roundtrip", builder, {16'd1, 16'd2, 16'd3, 16'd4});

    // back-to-back windows
    in_data = w1; in_valid = 1'b1;
    tick();
    in_data = w2;
    for (int i = 0; i < 8; i++) begin
      chk("t2_valid", out_valid, 1);
      chk("t2_data", out_data, exp2[i]);
      chk("t2_last", out_last, i % 4 == 3);
      chk("t2_in_ready", in_ready, i % 4 == 3);
      if (i == 4) begin
        chk("t2_roundtrip_w1", builder, w1);
        in_valid = 1'b0; in_data = '0;
      end
      tick();
    end
    chk("t2_idle_valid", out_valid, 0);
    chk("t2_roundtrip_w2", builder, w2);

    // backpressure with out_ready pattern 1,0,0,1
    in_data = w3; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_data = w1;
    k = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      out_ready = pat[3 - c % 4];
      #1;
      chk("t3_valid", out_valid, 1);
      chk("t3_data", out_data, exp3[k]);
      chk("t3_in_ready", in_ready, k == 3 && out_ready);
      tick();
      if (out_ready) k++;
    end
    chk("t3_all_sent", k, 4);
    out_ready = 1'b1;
    #1;
    chk("t3_idle_valid", out_valid, 0);
    chk("t3_roundtrip", builder, w3);

    // signed extremes
    in_data = w4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t4_data", out_data, exp4[i]);
      chk("t4_last", out_last, i == 3);
      tick();
    end
    chk("t4_roundtrip", builder, w4);

    // reset after two samples sent
    in_data = w1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t5_first", out_data, 16'd10);
    tick(); tick();
    chk("t5_third_pending", out_data, 16'd30);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_data", out_data, 0);
    chk("t5_rst_last", out_last, 0);
    chk("t5_rst_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_rel_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t5_no_samples", out_valid, 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
